adc_fill_tracker: RTL and testbench

Multi-channel successor to the single fill-number up-counter. It tracks the run's fill number across N_CH ADC channels. A fill is complete only when every enabled channel has reported done, or when a skew timeout expires. On completion it emits a one-cycle completion strobe carrying the fill number and the mask of missing channels. It sits between the per-channel ADC readout controllers and the event header builder.

---
 rtl/adc_fill_pkg.sv | 20 ++
 rtl/adc_sync_bit.sv | 30 +++
 rtl/adc_fill_tracker.sv | 195 +++++++++++++++++++
 tb/tb_adc_fill_tracker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fill_pkg.sv
// Shared types and defaults for the multi-channel ADC fill tracker.
package adc_fill_pkg;

    // Fill FSM: waiting for the first channel, or gathering the rest.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int DEF_WIDTH       = 24;
    localparam int DEF_N_CH        = 5;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed for a skew timer that counts from 1 up to TIMEOUT inclusive.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 32'sd1);
    endfunction

endpackage

// File: rtl/adc_sync_bit.sv
// Multi-flop synchroniser for a single slow-control level signal.
module adc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the asynchronous input one stage further along the chain.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain flops clear to 0 so a reset never looks like an init request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/adc_fill_tracker.sv
// Tracks the run fill number across several ADC channels. A fill closes when
// every enabled channel has reported done, or when the skew timer measured
// from the first done of the fill expires; closing emits a one-cycle strobe
// with the fill number and the mask of channels that never reported.
module adc_fill_tracker
    import adc_fill_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N_CH        = DEF_N_CH,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] initial_fill_num,
    input  logic [N_CH-1:0]  ch_enable,
    input  logic [N_CH-1:0]  ch_done,
    output logic [WIDTH-1:0] fill_num,
    output logic             fill_valid,
    output logic [WIDTH-1:0] fill_valid_num,
    output logic [N_CH-1:0]  fill_missing,
    output logic [N_CH-1:0]  err_overrun,
    output logic             err_timeout,
    output logic             wrap
);

    localparam int              TW          = timer_width(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_ONE   = TW'(32'd1);
    localparam logic [WIDTH-1:0] FILL_ONE   = WIDTH'(32'd1);

    // Synchronised init level
    logic init_sync_s;

    // State and datapath registers
    state_e           state_q,          state_d;
    logic [WIDTH-1:0] fill_num_q,       fill_num_d;
    logic [N_CH-1:0]  en_mask_q,        en_mask_d;
    logic [N_CH-1:0]  pending_q,        pending_d;
    logic [TW-1:0]    timer_q,          timer_d;
    logic             fill_valid_q,     fill_valid_d;
    logic [WIDTH-1:0] fill_valid_num_q, fill_valid_num_d;
    logic [N_CH-1:0]  fill_missing_q,   fill_missing_d;
    logic [N_CH-1:0]  err_overrun_q,    err_overrun_d;
    logic             err_timeout_q,    err_timeout_d;
    logic             wrap_q,           wrap_d;

    // Per-cycle helpers
    logic [N_CH-1:0]  new_s;            // enabled channels reporting this cycle
    logic [N_CH-1:0]  seen_s;           // channels reported so far including this cycle
    logic [N_CH-1:0]  dup_s;            // channels reporting a second time in this fill
    logic             close_s;          // fill closes at this edge
    logic [N_CH-1:0]  close_missing_s;  // missing mask reported with the close

    adc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_init_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (init),
        .q     (init_sync_s)
    );

    // Mask incoming done pulses to the participating channels and merge with pending.
    always_comb begin
        new_s  = ch_done & en_mask_q;
        seen_s = pending_q | new_s;
        dup_s  = pending_q & new_s;
    end

    // Fill FSM next-state, datapath next values and completion outputs.
    always_comb begin
        state_d          = state_q;
        fill_num_d       = fill_num_q;
        en_mask_d        = en_mask_q;
        pending_d        = pending_q;
        timer_d          = timer_q;
        fill_valid_d     = 1'b0;
        fill_valid_num_d = fill_valid_num_q;
        fill_missing_d   = fill_missing_q;
        err_overrun_d    = err_overrun_q;
        err_timeout_d    = err_timeout_q;
        wrap_d           = 1'b0;
        close_s          = 1'b0;
        close_missing_s  = '0;

        if (init_sync_s) begin
            // Reload wins over everything; any partial fill is dropped silently.
            fill_num_d    = initial_fill_num;
            en_mask_d     = ch_enable;
            pending_d     = '0;
            timer_d       = '0;
            err_overrun_d = '0;
            err_timeout_d = 1'b0;
            state_d       = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_s != '0) begin
                        if (new_s == en_mask_q) begin
                            // All enabled channels arrived together: no dwell in COLLECT.
                            close_s = 1'b1;
                        end else begin
                            pending_d = new_s;
                            timer_d   = TIMER_ONE;
                            state_d   = COLLECT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                COLLECT: begin
                    // A repeat report is flagged and otherwise dropped.
                    err_overrun_d = err_overrun_q | dup_s;
                    if (seen_s == en_mask_q) begin
                        close_s = 1'b1;
                    end else if (timer_q == TIMER_LIMIT) begin
                        close_s         = 1'b1;
                        close_missing_s = en_mask_q & ~seen_s;
                        err_timeout_d   = 1'b1;
                    end else begin
                        pending_d = seen_s;
                        timer_d   = timer_q + TIMER_ONE;
                    end
                end

                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                    timer_d   = '0;
                end
            endcase

            if (close_s) begin
                fill_valid_d     = 1'b1;
                fill_valid_num_d = fill_num_q;
                fill_missing_d   = close_missing_s;
                fill_num_d       = fill_num_q + FILL_ONE;
                wrap_d           = &fill_num_q;
                pending_d        = '0;
                timer_d          = '0;
                state_d          = IDLE;
            end else begin
                fill_valid_num_d = fill_valid_num_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_num_q       <= '0;
            en_mask_q        <= '0;
            pending_q        <= '0;
            timer_q          <= '0;
            fill_valid_q     <= 1'b0;
            fill_valid_num_q <= '0;
            fill_missing_q   <= '0;
            err_overrun_q    <= '0;
            err_timeout_q    <= 1'b0;
            wrap_q           <= 1'b0;
        end else begin
            fill_num_q       <= fill_num_d;
            en_mask_q        <= en_mask_d;
            pending_q        <= pending_d;
            timer_q          <= timer_d;
            fill_valid_q     <= fill_valid_d;
            fill_valid_num_q <= fill_valid_num_d;
            fill_missing_q   <= fill_missing_d;
            err_overrun_q    <= err_overrun_d;
            err_timeout_q    <= err_timeout_d;
            wrap_q           <= wrap_d;
        end
    end

    assign fill_num       = fill_num_q;
    assign fill_valid     = fill_valid_q;
    assign fill_valid_num = fill_valid_num_q;
    assign fill_missing   = fill_missing_q;
    assign err_overrun    = err_overrun_q;
    assign err_timeout    = err_timeout_q;
    assign wrap           = wrap_q;

endmodule

// File: tb/tb_adc_fill_tracker.sv
// Scoreboard bench for adc_fill_tracker: a behavioural model predicts each
// cycle's outputs and every completion; a monitor compares at the falling edge.
module tb_adc_fill_tracker;

    localparam int WIDTH   = 24;
    localparam int N_CH    = 5;
    localparam int TIMEOUT = 16;
    localparam int SYNC    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             init = 1'b0;
    logic [WIDTH-1:0] initial_fill_num = '0;
    logic [N_CH-1:0]  ch_enable = '0;
    logic [N_CH-1:0]  ch_done = '0;
    logic [WIDTH-1:0] fill_num;
    logic             fill_valid;
    logic [WIDTH-1:0] fill_valid_num;
    logic [N_CH-1:0]  fill_missing;
    logic [N_CH-1:0]  err_overrun;
    logic             err_timeout;
    logic             wrap;

    always #5 clk = ~clk;

    adc_fill_tracker #(
        .WIDTH       (WIDTH),
        .N_CH        (N_CH),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init             (init),
        .initial_fill_num (initial_fill_num),
        .ch_enable        (ch_enable),
        .ch_done          (ch_done),
        .fill_num         (fill_num),
        .fill_valid       (fill_valid),
        .fill_valid_num   (fill_valid_num),
        .fill_missing     (fill_missing),
        .err_overrun      (err_overrun),
        .err_timeout      (err_timeout),
        .wrap             (wrap)
    );

    typedef struct {
        logic [WIDTH-1:0] num;
        logic [N_CH-1:0]  missing;
    } comp_t;

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] fnum;
        logic [N_CH-1:0]  ov;
        logic             to;
        logic             wrap;
    } st_t;

    comp_t comp_q[$];
    st_t   st_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model state: which channels this fill has seen, when it opened.
    logic [WIDTH-1:0] m_fill;
    logic [N_CH-1:0]  m_en, m_seen, m_ov;
    logic             m_to, m_open;
    int               m_edge, m_first;
    logic             init_hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill = '0; m_en = '0; m_seen = '0; m_ov = '0;
        m_to = 1'b0; m_open = 1'b0; m_edge = 0; m_first = 0;
        init_hist.delete();
        comp_q.delete();
        st_q.delete();
    endtask

    // One clock edge of the reference model; pushes its predictions.
    task automatic model_step(input logic i, input logic [WIDTH-1:0] ifn,
                              input logic [N_CH-1:0] en, input logic [N_CH-1:0] done);
        logic          sync_now;
        logic [N_CH-1:0] d;
        logic          closing;
        logic [N_CH-1:0] miss;
        st_t           s;
        comp_t         c;
        m_edge++;
        closing = 1'b0;
        miss = '0;
        s.wrap = 1'b0;
        sync_now = 1'b0;
        init_hist.push_back(i);
        if (init_hist.size() > SYNC) sync_now = init_hist.pop_front();
        if (sync_now) begin
            m_fill = ifn; m_en = en; m_open = 1'b0; m_seen = '0;
            m_ov = '0; m_to = 1'b0;
        end else begin
            d = done & m_en;
            if (!m_open) begin
                if (d != '0) begin
                    if (d == m_en) closing = 1'b1;
                    else begin
                        m_open = 1'b1; m_seen = d; m_first = m_edge;
                    end
                end
            end else begin
                m_ov = m_ov | (d & m_seen);
                m_seen = m_seen | d;
                if (m_seen == m_en) closing = 1'b1;
                else if (m_edge - m_first == TIMEOUT) begin
                    closing = 1'b1;
                    miss = m_en & ~m_seen;
                    m_to = 1'b1;
                end
            end
            if (closing) begin
                c.num = m_fill;
                c.missing = miss;
                comp_q.push_back(c);
                s.wrap = (m_fill == {WIDTH{1'b1}});
                m_fill = m_fill + 1'b1;
                m_open = 1'b0;
                m_seen = '0;
            end
        end
        s.valid = closing;
        s.fnum  = m_fill;
        s.ov    = m_ov;
        s.to    = m_to;
        st_q.push_back(s);
    endtask

    task automatic step(input logic i, input logic [N_CH-1:0] d);
        init = i;
        ch_done = d;
        model_step(i, initial_fill_num, ch_enable, d);
        @(negedge clk);
        #1;
    endtask

    task automatic do_init(input logic [WIDTH-1:0] v, input logic [N_CH-1:0] en);
        initial_fill_num = v;
        ch_enable = en;
        step(1'b1, '0);
        step(1'b1, '0);
        repeat (SYNC + 2) step(1'b0, '0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " fill_num"}, fill_num, 64'd0);
        check({tag, " fill_valid"}, fill_valid, 64'd0);
        check({tag, " fill_valid_num"}, fill_valid_num, 64'd0);
        check({tag, " fill_missing"}, fill_missing, 64'd0);
        check({tag, " err_overrun"}, err_overrun, 64'd0);
        check({tag, " err_timeout"}, err_timeout, 64'd0);
        check({tag, " wrap"}, wrap, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        init = 1'b0;
        ch_done = '0;
        #1;
        check_zero("reset");
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle state compare plus completion scoreboard.
    initial begin
        st_t   s;
        comp_t c;
        forever begin
            @(negedge clk);
            if (rst_n && st_q.size() > 0) begin
                s = st_q.pop_front();
                check("fill_valid", fill_valid, s.valid);
                check("fill_num", fill_num, s.fnum);
                check("err_overrun", err_overrun, s.ov);
                check("err_timeout", err_timeout, s.to);
                check("wrap", wrap, s.wrap);
                if (fill_valid) begin
                    if (comp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_fill_valid: got num %0h, none expected", fill_valid_num);
                    end else begin
                        c = comp_q.pop_front();
                        check("fill_valid_num", fill_valid_num, c.num);
                        check("fill_missing", fill_missing, c.missing);
                    end
                end else if (s.valid && comp_q.size() > 0) begin
                    c = comp_q.pop_front();
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0]      rnd;
        logic [N_CH-1:0]  en;
        logic [WIDTH-1:0] ifn;
        int               dens;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Reload and single completion
        do_init(24'd100, 5'b11111);
        step(1'b0, 5'b00001); step(1'b0, 5'b00010); step(1'b0, 5'b00100);
        step(1'b0, 5'b01000); step(1'b0, 5'b10000); step(1'b0, 5'b00000);
        check("t1 fill_num", fill_num, 64'd101);

        // Simultaneous done
        do_init(24'd7, 5'b00101);
        step(1'b0, 5'b00101); step(1'b0, 5'b00000);

        // Timeout
        do_init(24'd200, 5'b11111);
        step(1'b0, 5'b00001); step(1'b0, 5'b00010);
        repeat (20) step(1'b0, 5'b00000);
        check("t3 err_timeout", err_timeout, 64'd1);

        // Overrun
        do_init(24'd300, 5'b11111);
        step(1'b0, 5'b00100); step(1'b0, 5'b00100); step(1'b0, 5'b01000);
        step(1'b0, 5'b00001); step(1'b0, 5'b00010); step(1'b0, 5'b10000);
        step(1'b0, 5'b00000);
        check("t4 err_overrun", err_overrun, 64'h04);
        check("t4 fill_num", fill_num, 64'd301);

        // Overrun on the closing edge, then a done during the strobe cycle
        do_init(24'd400, 5'b00011);
        step(1'b0, 5'b00001); step(1'b0, 5'b00011); step(1'b0, 5'b00001);
        step(1'b0, 5'b00010); step(1'b0, 5'b00000);
        check("t5 fill_num", fill_num, 64'd402);

        // Wrap
        do_init(24'hFFFFFF, 5'b11111);
        step(1'b0, 5'b11111); step(1'b0, 5'b00000);
        check("t6 fill_num", fill_num, 64'd0);

        // Reset mid-collect
        do_init(24'd500, 5'b11111);
        step(1'b0, 5'b00001); step(1'b0, 5'b00010);
        do_reset();
        repeat (4) step(1'b0, 5'b00000);

        // Init mid-collect
        do_init(24'd600, 5'b11111);
        step(1'b0, 5'b00001); step(1'b0, 5'b00010);
        do_init(24'd777, 5'b11111);
        repeat (TIMEOUT + 4) step(1'b0, 5'b00000);
        check("t8 fill_num", fill_num, 64'd777);

        // Randomized traffic with varied masks, densities and reload values
        for (int r = 0; r < 12; r++) begin
            rnd = $urandom;
            en  = rnd[N_CH-1:0];
            if (r == 3) en = '0;
            rnd = $urandom;
            ifn = (r % 4 == 0) ? 24'hFFFFFE : rnd[WIDTH-1:0];
            if (r == 7) do_reset();
            do_init(ifn, en);
            dens = 1 + (r % 4) * 3;
            for (int k = 0; k < 250; k++) begin
                rnd = $urandom;
                if ($urandom_range(0, dens) == 0) step(1'b0, rnd[N_CH-1:0]);
                else step(1'b0, 5'b00000);
            end
        end

        repeat (3) step(1'b0, 5'b00000);
        check("leftover completions", comp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
